// File: rtl/dsp_pkg.sv
// dsp_pkg: shared DSP width defaults, MAC mode encodings and a saturating adder
package dsp_pkg;
    localparam int DSP_WIDTH_A     = 18;
    localparam int DSP_WIDTH_B     = 18;
    localparam int DSP_WIDTH_ACC   = 48;
    localparam int DSP_MULT_STAGES = 2;
    localparam int DSP_CNT_W       = 16;
    localparam int SAT_MAX_W       = 128;

    typedef enum logic {
        MAC_MODE_MUL = 1'b0,
        MAC_MODE_ACC = 1'b1
    } mac_mode_e;

    // Operands arrive already extended to SAT_MAX_W from w bits; the result clamps to w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input  logic [SAT_MAX_W-1:0] a,
        input  logic [SAT_MAX_W-1:0] b,
        input  int unsigned          w,
        input  logic                 sgn,
        output logic                 ovf
    );
        logic [SAT_MAX_W-1:0] s, hi, lo;
        s   = a + b;
        hi  = sgn ? (SAT_MAX_W'(1) << (w - 1)) - 1 : (SAT_MAX_W'(1) << w) - 1;
        lo  = sgn ? ~hi : '0;
        ovf = sgn ? ($signed(s) > $signed(hi)) || ($signed(s) < $signed(lo)) : (s > hi);
        return ovf ? ((sgn && s[SAT_MAX_W-1]) ? lo : hi) : s;
    endfunction
endpackage

// File: rtl/dsp_mult_pipe.sv
// dsp_mult_pipe: registered operands followed by MULT_STAGES product registers,
// carrying an opaque sideband bus alongside each beat.
module dsp_mult_pipe
    import dsp_pkg::*;
#(
    parameter int WIDTH_A     = DSP_WIDTH_A,
    parameter int WIDTH_B     = DSP_WIDTH_B,
    parameter int MULT_STAGES = DSP_MULT_STAGES,
    parameter int SIGNED      = 1,
    parameter int SB_W        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    input  logic [SB_W-1:0]            in_sb,
    output logic [WIDTH_A+WIDTH_B-1:0] out_p,
    output logic [SB_W-1:0]            out_sb
);
    localparam int PW = WIDTH_A + WIDTH_B;

    logic [WIDTH_A-1:0] a_q;
    logic [WIDTH_B-1:0] b_q;
    logic [SB_W-1:0]    sb_q;
    logic [PW-1:0]      ae, be, prod;
    logic [PW-1:0]      p_r [MULT_STAGES];
    logic [SB_W-1:0]    s_r [MULT_STAGES];

    // Extending both operands to the full product width makes a single
    // modulo-2^PW multiply exact for signed and unsigned alike.
    assign ae   = {{WIDTH_B{(SIGNED != 0) && a_q[WIDTH_A-1]}}, a_q};
    assign be   = {{WIDTH_A{(SIGNED != 0) && b_q[WIDTH_B-1]}}, b_q};
    assign prod = ae * be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            sb_q <= '0;
            for (int i = 0; i < MULT_STAGES; i++) begin
                p_r[i] <= '0;
                s_r[i] <= '0;
            end
        end else if (ce) begin
            a_q    <= in_a;
            b_q    <= in_b;
            sb_q   <= in_sb;
            p_r[0] <= prod;
            s_r[0] <= sb_q;
            for (int i = 1; i < MULT_STAGES; i++) begin
                p_r[i] <= p_r[i-1];
                s_r[i] <= s_r[i-1];
            end
        end
    end

    assign out_p  = p_r[MULT_STAGES-1];
    assign out_sb = s_r[MULT_STAGES-1];
endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pipelined multiplier with framed saturating accumulation,
// global clock enable and registered outputs.
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int WIDTH_A     = DSP_WIDTH_A,
    parameter int WIDTH_B     = DSP_WIDTH_B,
    parameter int WIDTH_ACC   = DSP_WIDTH_ACC,
    parameter int MULT_STAGES = DSP_MULT_STAGES,
    parameter int SIGNED      = 1,
    parameter int CNT_W       = DSP_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [WIDTH_A-1:0]   in_a,
    input  logic [WIDTH_B-1:0]   in_b,
    input  logic                 in_mode,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    output logic [WIDTH_ACC-1:0] out_data,
    output logic                 out_ovf,
    output logic [CNT_W-1:0]     out_cnt
);
    localparam int PW = WIDTH_A + WIDTH_B;

    if (WIDTH_ACC < PW) begin : g_bad_acc
        $error("dsp_mac_pipe: WIDTH_ACC must be >= WIDTH_A+WIDTH_B");
    end
    if (MULT_STAGES < 1) begin : g_bad_stages
        $error("dsp_mac_pipe: MULT_STAGES must be >= 1");
    end
    if (WIDTH_ACC > SAT_MAX_W - 2) begin : g_bad_wide
        $error("dsp_mac_pipe: WIDTH_ACC exceeds saturating adder range");
    end

    logic [PW-1:0]        p;
    logic                 v, m, f, l;
    logic [WIDTH_ACC-1:0] ext, acc, acc_n, acc_sum;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 ovf, ovf_n, sum_ovf, is_acc, emit;

    dsp_mult_pipe #(
        .WIDTH_A    (WIDTH_A),
        .WIDTH_B    (WIDTH_B),
        .MULT_STAGES(MULT_STAGES),
        .SIGNED     (SIGNED),
        .SB_W       (4)
    ) u_mult (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .in_a  (in_a),
        .in_b  (in_b),
        .in_sb ({in_valid, in_mode, in_first, in_last}),
        .out_p (p),
        .out_sb({v, m, f, l})
    );

    assign ext    = (SIGNED != 0) ? WIDTH_ACC'($signed(p)) : WIDTH_ACC'(p);
    assign is_acc = v && (m == MAC_MODE_ACC);
    assign emit   = v && (!is_acc || l);

    always_comb begin
        sum_ovf = 1'b0;
        acc_sum = WIDTH_ACC'(sat_add(
            (SIGNED != 0) ? SAT_MAX_W'($signed(acc)) : SAT_MAX_W'(acc),
            (SIGNED != 0) ? SAT_MAX_W'($signed(ext)) : SAT_MAX_W'(ext),
            WIDTH_ACC, SIGNED != 0, sum_ovf));
        acc_n = !is_acc ? acc : f ? ext : acc_sum;
        cnt_n = !is_acc ? cnt : f ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
        ovf_n = !is_acc ? ovf : f ? 1'b0 : (ovf || sum_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_cnt   <= '0;
        end else if (ce) begin
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf       <= ovf_n;
            out_valid <= emit;
            if (emit) begin
                out_data <= is_acc ? acc_n : ext;
                out_ovf  <= is_acc && ovf_n;
                out_cnt  <= is_acc ? cnt_n : CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed scenarios plus randomized traffic against an arithmetic
// frame model, on a default instance and a 36-bit accumulator instance.
module tb_dsp_mac_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0, in_valid = 1'b0, in_mode = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [17:0] in_a = '0, in_b = '0;
    logic        o_valid0, o_ovf0, o_valid1, o_ovf1;
    logic [47:0] o_data0;
    logic [35:0] o_data1;
    logic [15:0] o_cnt0, o_cnt1;

    always #5 clk = ~clk;

    dsp_mac_pipe dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(o_valid0), .out_data(o_data0), .out_ovf(o_ovf0), .out_cnt(o_cnt0)
    );

    dsp_mac_pipe #(.WIDTH_ACC(36)) dut36 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
        .out_valid(o_valid1), .out_data(o_data1), .out_ovf(o_ovf1), .out_cnt(o_cnt1)
    );

    typedef struct {
        longint data;
        bit     ovf;
        int     cnt;
        int     due;
    } exp_t;

    exp_t        q0[$], q1[$];
    longint      macc[2];
    int          mcnt[2];
    bit          movf[2];
    longint      last_d[2];
    int          last_c[2], last_t[2], nout[2];
    bit          last_o[2];
    int          k = 0, t = 0, errors = 0, checks = 0;
    logic [65:0] prev0 = '0;
    logic [53:0] prev1 = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame semantics in plain integer arithmetic; results are due MULT_STAGES+1 accepted edges later.
    task automatic model_beat();
        longint p, s, hi, lo;
        int     w;
        bit     push;
        exp_t   e;
        p = longint'($signed(in_a)) * longint'($signed(in_b));
        for (int d = 0; d < 2; d++) begin
            w    = (d == 0) ? 48 : 36;
            hi   = (longint'(1) << (w - 1)) - 1;
            lo   = -hi - 1;
            push = 1'b0;
            if (!in_mode) begin
                e.data = p; e.ovf = 1'b0; e.cnt = 1; push = 1'b1;
            end else begin
                if (in_first) begin
                    macc[d] = p; mcnt[d] = 1; movf[d] = 1'b0;
                end else begin
                    s = macc[d] + p;
                    if (s > hi) begin s = hi; movf[d] = 1'b1; end
                    else if (s < lo) begin s = lo; movf[d] = 1'b1; end
                    macc[d] = s;
                    if (mcnt[d] < 65535) mcnt[d]++;
                end
                if (in_last) begin
                    e.data = macc[d]; e.ovf = movf[d]; e.cnt = mcnt[d]; push = 1'b1;
                end
            end
            e.due = k + 3;
            if (push && d == 0) q0.push_back(e);
            if (push && d == 1) q1.push_back(e);
        end
    endtask

    task automatic score(input int d, input bit v, input longint data, input int cnt, input bit ovf);
        exp_t e;
        bit   due;
        due = (d == 0) ? (q0.size() > 0 && q0[0].due == k) : (q1.size() > 0 && q1[0].due == k);
        check($sformatf("valid%0d@%0d", d, k), v, due);
        if (due) begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (v) begin
                check($sformatf("data%0d@%0d", d, k), data, e.data);
                check($sformatf("cnt%0d@%0d", d, k), cnt, e.cnt);
                check($sformatf("ovf%0d@%0d", d, k), ovf, e.ovf);
            end
        end
        if (v) begin
            last_d[d] = data; last_c[d] = cnt; last_o[d] = ovf; last_t[d] = t; nout[d]++;
        end
    endtask

    task automatic step(input bit c, input bit v, input int a, input int b,
                        input bit m, input bit f, input bit l);
        @(negedge clk);
        ce = c; in_valid = v; in_a = 18'(a); in_b = 18'(b);
        in_mode = m; in_first = f; in_last = l;
        @(posedge clk);
        #1;
        t++;
        if (c) begin
            k++;
            score(0, o_valid0, longint'($signed(o_data0)), int'(o_cnt0), o_ovf0);
            score(1, o_valid1, longint'($signed(o_data1)), int'(o_cnt1), o_ovf1);
            if (v) model_beat();
        end else begin
            check("hold0", {o_valid0, o_ovf0, o_cnt0, o_data0}, prev0);
            check("hold1", {o_valid1, o_ovf1, o_cnt1, o_data1}, prev1);
        end
        prev0 = {o_valid0, o_ovf0, o_cnt0, o_data0};
        prev1 = {o_valid1, o_ovf1, o_cnt1, o_data1};
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; ce = 1'b1;
        #1;
        check("rst_out0", {o_valid0, o_ovf0, o_cnt0, o_data0}, 66'b0);
        check("rst_out1", {o_valid1, o_ovf1, o_cnt1, o_data1}, 54'b0);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            macc[d] = 0; mcnt[d] = 0; movf[d] = 1'b0;
        end
        prev0 = '0;
        prev1 = '0;
    endtask

    function automatic int rand_op();
        case ($urandom_range(0, 5))
            0:       return -131072;
            1:       return 131071;
            default: return int'($urandom_range(0, 262143)) - 131072;
        endcase
    endfunction

    initial begin
        int n, t0;
        do_reset();

        t0 = t;
        step(1, 1, 3, -4, 0, 0, 0);
        bubbles(4);
        check("mul_data", last_d[0], -12);
        check("mul_cnt", last_c[0], 1);
        check("mul_ovf", last_o[0], 0);
        check("mul_lat", last_t[0] - t0, 4);

        n = nout[0]; t0 = t;
        step(1, 1, 2, 3, 1, 1, 0);
        step(1, 1, 4, 5, 1, 0, 0);
        step(1, 1, 6, 7, 1, 0, 1);
        bubbles(5);
        check("frame_nout", nout[0] - n, 1);
        check("frame_data", last_d[0], 68);
        check("frame_cnt", last_c[0], 3);
        check("frame_lat", last_t[0] - t0, 6);

        step(1, 1, -131072, -131072, 1, 1, 1);
        bubbles(4);
        check("single_data", last_d[0], 64'd17179869184);
        check("single_cnt", last_c[0], 1);

        step(1, 1, -131072, -131072, 1, 1, 0);
        step(1, 1, -131072, -131072, 1, 0, 0);
        step(1, 1, -131072, -131072, 1, 0, 1);
        bubbles(4);
        check("sat_data", last_d[1], 64'd34359738367);
        check("sat_ovf", last_o[1], 1);
        check("sat_cnt", last_c[1], 3);
        check("nosat_data", last_d[0], 64'd51539607552);
        check("nosat_ovf", last_o[0], 0);
        step(1, 1, 1, 1, 1, 1, 1);
        bubbles(4);
        check("sat_clear_ovf", last_o[1], 0);
        check("sat_clear_data", last_d[1], 1);

        n = nout[0]; t0 = t;
        step(1, 1, 2, 3, 1, 1, 0);
        step(1, 1, 4, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 99, 99, 1, 1, 1);
        step(1, 1, 6, 7, 1, 0, 1);
        bubbles(5);
        check("stall_nout", nout[0] - n, 1);
        check("stall_data", last_d[0], 68);
        check("stall_lat", last_t[0] - t0, 9);

        n = nout[0];
        step(1, 1, 2, 3, 1, 1, 0);
        step(1, 1, 4, 5, 1, 0, 0);
        do_reset();
        bubbles(4);
        check("rst_nout", nout[0] - n, 0);
        step(1, 1, 5, 5, 1, 0, 1);
        bubbles(4);
        check("rst_data", last_d[0], 25);
        check("rst_cnt", last_c[0], 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 99) < 85, $urandom_range(0, 9) < 8, rand_op(), rand_op(),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        bubbles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised pipelined multiply-accumulate engine for the DSP datapath. Operand widths, multiplier pipeline depth, signedness and accumulator width are configurable. A global clock-enable stalls the whole pipeline. Per-beat sideband selects plain multiply or framed accumulation, and accumulation saturates with an overflow flag. It sits between sample sources (filters, correlators) and result consumers, and replaces the fixed two-stage multiplier where accumulation or stalls are needed.

## Interface
- `WIDTH_A`, default 18: operand A width.
- `WIDTH_B`, default 18: operand B width.
- `WIDTH_ACC`, default 48: accumulator/result width. Must be ≥ `WIDTH_A+WIDTH_B`; elaboration error otherwise.
- `MULT_STAGES`, default 2: product pipeline registers. Must be ≥ 1.
- `SIGNED`, default 1: 1 = two's-complement operands and result; 0 = unsigned.
- `CNT_W`, default 16: term-counter width.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `ce` in 1: clock enable. When low, every register holds.
- `in_valid` in 1: input beat valid.
- `in_a` in `WIDTH_A`: operand A.
- `in_b` in `WIDTH_B`: operand B.
- `in_mode` in 1: 0 = multiply only, 1 = accumulate.
- `in_first` in 1: accumulate mode only; start a new sum with this beat.
- `in_last` in 1: accumulate mode only; emit the sum after this beat.
- `out_valid` out 1: result valid, one cycle per result.
- `out_data` out `WIDTH_ACC`: result.
- `out_ovf` out 1: saturation occurred in this result.
- `out_cnt` out `CNT_W`: number of terms in this result. Always 1 in mode 0.

## Operation
- Pipeline: input register → `MULT_STAGES` product registers → accumulator/output register. `valid`, `mode`, `first` and `last` travel alongside as sideband.
- Product: full-width `WIDTH_A+WIDTH_B`, sign-extended (`SIGNED`=1) or zero-extended (`SIGNED`=0) to `WIDTH_ACC`.
- Mode 0: `out_data` = extended product, `out_valid` = 1, `out_ovf` = 0, `out_cnt` = 1. The accumulator is untouched.
- Mode 1, `first`=1: acc ← product, cnt ← 1, ovf ← 0.
- Mode 1, `first`=0: acc ← sat(acc + product), cnt ← cnt+1, with cnt saturating at all-ones. ovf is sticky, set on any clamp.
- Mode 1 emit: when `last`=1, drive `out_data`=new acc, `out_ovf`, `out_cnt`, and pulse `out_valid`. Accumulator state remains after emission; a following beat without `first` continues the sum.
- `first` and `last` on the same beat: single-term result.
- Saturation, signed: clamp to 2^(W-1)-1 or -2^(W-1).
- Saturation, unsigned: clamp to 2^W-1. Unsigned addition cannot underflow.
- Beats with `in_valid`=0 are bubbles: the accumulator holds and `out_valid`=0. Interleaving mode-0 beats inside a mode-1 frame is legal and does not disturb the accumulator.
- `in_first`/`in_last` are ignored when `in_mode`=0 or `in_valid`=0.

## Timing
- Reset values: all pipeline registers, accumulator, counter and sticky flag cleared. `out_valid`=0, `out_data`=0, `out_ovf`=0, `out_cnt`=0.
- Latency: a beat accepted at ce-high edge N appears at outputs after edge N+`MULT_STAGES`+1. That is `MULT_STAGES`+2 ce-high cycles from presenting the input; 4 cycles at default.
- `ce` low: outputs, including `out_valid`, hold their values. Consumers must qualify with `ce`. Inputs are not sampled.
- Throughput: one beat per ce-high cycle, with no back-to-back restrictions.
- `rst` asserted mid-frame: in-flight beats and the partial sum are discarded. After release, a `last` without `first` sums from 0.
- The outputs are registered, with no combinational path from inputs.

## Structure
- Shared package `dsp_pkg`:
  - default width constants;
  - mode encodings `MAC_MODE_MUL`=0 and `MAC_MODE_ACC`=1;
  - a signed/unsigned saturating-add function reused by other DSP blocks.
- Sub-module `dsp_mult_pipe`: input register plus `MULT_STAGES` product pipeline, with `ce`, `rst` and a pass-through sideband bus of parametrised width.
- The top level holds the accumulator/saturation/output stage.

## Test plan
All scenarios use defaults (18/18/48, `MULT_STAGES`=2, `SIGNED`=1) unless stated otherwise.
- **Multiply only:** mode 0, a=3, b=-4, one beat at cycle 0 → cycle 4: `out_valid`=1, `out_data`=-12, `out_cnt`=1, `out_ovf`=0.
- **Framed accumulation:** mode 1, beats (2,3, first), (4,5), (6,7, last) back-to-back → exactly one `out_valid`, `out_data`=68, `out_cnt`=3. No output for the first two beats.
- **Single-term frame:** first+last same beat, a=b=-131072 → `out_data`=17179869184 (2^34), `out_cnt`=1.
- **Saturation:** `WIDTH_ACC`=36; frame of three beats a=b=-131072 → `out_data`=34359738367 (2^35-1), `out_ovf`=1, `out_cnt`=3. Next frame with first → `out_ovf`=0.
- **Stall:** `ce` low for 3 cycles in the middle of scenario 2 → result arrives 3 cycles later, still 68, and outputs hold steady while stalled.
- **Reset mid-frame:** assert `rst` after the second beat of scenario 2 → `out_valid` stays 0. After release, mode 1 (5,5, last) alone → `out_data`=25, `out_cnt`=1.
